// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the UART-to-memory DMA controller.
//   dma_state_t     : FSM state encoding (IDLE / READ_UART / WRITE_MEM)
//   DEFAULT_*_WIDTH : default widths for data, address and byte count
package dma_ctrl_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
  localparam int unsigned DEFAULT_SIZE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    READ_UART = 2'b01,
    WRITE_MEM = 2'b10
  } dma_state_t;

endpackage

// File: rtl/dma_start_edge_detect.sv
// Rising-edge detector for the DMA start request.
// Ports:
//   clk        : clock
//   rstn       : asynchronous reset, active-high
//   start      : level request from the host
//   start_rise : high for the cycle where start is 1 and was 0 on the previous edge
module dma_start_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic start_rise
);

  logic start_d;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      start_d <= 1'b0;
    end else begin
      start_d <= start;
    end
  end

  // A held-high start produces a single rise.
  assign start_rise = start & ~start_d;

endmodule

// File: rtl/dma_controller.sv
// UART-to-memory DMA engine. On a rising edge of start it moves transfer_size
// bytes from the UART receiver into consecutive memory locations starting at
// start_address, one memory write per byte, and raises a sticky done.
// Optional feature: define DMA_CTRL_SVA_EN to compile in protocol assertions.
// Ports:
//   clk, rstn            : clock, asynchronous active-high reset
//   start                : transfer request (rising edge acted on, in IDLE only)
//   uart_data/_valid     : received byte and its one-cycle qualifier
//   start_address        : first write address, sampled at start
//   transfer_size        : byte count, sampled at start (0 = immediate done)
//   uart_read_enable     : high while waiting for a UART byte
//   memory_write_address : write address (holds outside WRITE_MEM)
//   memory_write_data    : write data (holds outside WRITE_MEM)
//   memory_write_enable  : one-cycle write strobe
//   done                 : transfer complete, held until the next accepted start
module dma_controller
  import dma_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned SIZE_WIDTH = DEFAULT_SIZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] uart_data,
  input  logic                  uart_data_valid,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [SIZE_WIDTH-1:0] transfer_size,
  output logic                  uart_read_enable,
  output logic [ADDR_WIDTH-1:0] memory_write_address,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  output logic                  memory_write_enable,
  output logic                  done
);

  dma_state_t            current_state;
  logic                  start_rise;
  logic [ADDR_WIDTH-1:0] cur_address;
  logic [SIZE_WIDTH-1:0] remaining;

  dma_start_edge_detect u_start_edge (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .start_rise (start_rise)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      current_state        <= IDLE;
      cur_address          <= '0;
      remaining            <= '0;
      memory_write_address <= '0;
      memory_write_data    <= '0;
      done                 <= 1'b0;
    end else begin
      unique case (current_state)
        IDLE: begin
          if (start_rise) begin
            if (transfer_size != '0) begin
              cur_address   <= start_address;
              remaining     <= transfer_size;
              done          <= 1'b0;
              current_state <= READ_UART;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ_UART: begin
          if (uart_data_valid) begin
            // Address is copied here so the output port does not show the
            // post-increment value once the write is over.
            memory_write_data    <= uart_data;
            memory_write_address <= cur_address;
            current_state        <= WRITE_MEM;
          end
        end
        WRITE_MEM: begin
          cur_address <= cur_address + 1'b1;
          remaining   <= remaining - 1'b1;
          if (remaining == SIZE_WIDTH'(1)) begin
            done          <= 1'b1;
            current_state <= IDLE;
          end else begin
            current_state <= READ_UART;
          end
        end
        default: current_state <= IDLE;
      endcase
    end
  end

  // Both strobes decode directly from the state, so they can never overlap.
  assign uart_read_enable    = (current_state == READ_UART);
  assign memory_write_enable = (current_state == WRITE_MEM);

`ifdef DMA_CTRL_SVA_EN
  a_enables_exclusive : assert property (@(posedge clk) disable iff (rstn)
    !(uart_read_enable && memory_write_enable));
  a_write_in_write_mem : assert property (@(posedge clk) disable iff (rstn)
    memory_write_enable |-> (current_state == WRITE_MEM));
  a_write_single_cycle : assert property (@(posedge clk) disable iff (rstn)
    memory_write_enable |=> !memory_write_enable);
  a_done_only_idle : assert property (@(posedge clk) disable iff (rstn)
    (current_state != IDLE) |-> !done);
  a_state_legal : assert property (@(posedge clk) disable iff (rstn)
    current_state != 2'b11);
`else
`endif

endmodule

// File: tb/tb_dma_controller.sv
module tb_dma_controller;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic [7:0] start_address;
  logic [7:0] transfer_size;
  logic       uart_read_enable;
  logic [7:0] memory_write_address;
  logic [7:0] memory_write_data;
  logic       memory_write_enable;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log and read-enable cycle count, filled by the monitor only.
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         re_cnt = 0;

  logic [7:0] exp_wrap_addr[8] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic [7:0] exp_wrap_data[8] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
  logic [7:0] exp_four_addr[4] = '{8'h30, 8'h31, 8'h32, 8'h33};
  logic [7:0] exp_four_data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  dma_controller dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .start                (start),
    .uart_data            (uart_data),
    .uart_data_valid      (uart_data_valid),
    .start_address        (start_address),
    .transfer_size        (transfer_size),
    .uart_read_enable     (uart_read_enable),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .memory_write_enable  (memory_write_enable),
    .done                 (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rstn && memory_write_enable) begin
      wr_addr.push_back(memory_write_address);
      wr_data.push_back(memory_write_data);
    end
    if (!rstn && uart_read_enable) re_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] addr, input logic [7:0] size);
    start_address = addr;
    transfer_size = size;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Waits (bounded) for a byte request, idles 'gap' cycles, then supplies the byte.
  task automatic feed_byte(input string tag, input logic [7:0] d, input int gap);
    int k = 0;
    while (!uart_read_enable && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, " rd_en"}, 32'(uart_read_enable), 32'd1);
    tick(gap);
    uart_data = d;
    uart_data_valid = 1'b1;
    tick(1);
    uart_data_valid = 1'b0;
    uart_data = 8'h00;
    check({tag, " wr_en"}, 32'(memory_write_enable), 32'd1);
    check({tag, " rd_en low"}, 32'(uart_read_enable), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (!done && k < bound) begin
      tick(1);
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int base_wr;
    int base_re;

    rstn = 1'b1;
    start = 1'b0;
    uart_data = 8'h00;
    uart_data_valid = 1'b0;
    start_address = 8'h00;
    transfer_size = 8'h00;
    tick(3);
    rstn = 1'b0;
    tick(1);
    check("reset state", 32'(dut.current_state), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rd_en", 32'(uart_read_enable), 32'd0);
    check("reset wr_en", 32'(memory_write_enable), 32'd0);
    check("reset wr_addr", 32'(memory_write_address), 32'h00);

    // Single byte, data two cycles after the request.
    base_wr = wr_addr.size();
    pulse_start(8'h20, 8'd1);
    check("single rd_en after start", 32'(uart_read_enable), 32'd1);
    feed_byte("single", 8'hAB, 2);
    wait_done("single", 5);
    check("single nwrites", 32'(wr_addr.size() - base_wr), 32'd1);
    check("single addr", 32'(wr_addr[base_wr]), 32'h20);
    check("single data", 32'(wr_data[base_wr]), 32'hAB);
    check("single addr hold", 32'(memory_write_address), 32'h20);
    check("single data hold", 32'(memory_write_data), 32'hAB);
    check("single wr_en idle", 32'(memory_write_enable), 32'd0);

    // Four bytes: done must stay low until the fourth write ends.
    base_wr = wr_addr.size();
    pulse_start(8'h30, 8'd4);
    check("four done cleared", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      feed_byte($sformatf("four[%0d]", i), exp_four_data[i], i % 2);
      check($sformatf("four[%0d] done low", i), 32'(done), 32'd0);
    end
    wait_done("four", 3);
    check("four nwrites", 32'(wr_addr.size() - base_wr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("four addr[%0d]", i), 32'(wr_addr[base_wr + i]), 32'(exp_four_addr[i]));
      check($sformatf("four data[%0d]", i), 32'(wr_data[base_wr + i]), 32'(exp_four_data[i]));
    end

    // Eight bytes with address wrap past 0xFF.
    base_wr = wr_addr.size();
    pulse_start(8'hFE, 8'd8);
    for (int i = 0; i < 8; i++) begin
      feed_byte($sformatf("wrap[%0d]", i), exp_wrap_data[i], i % 3);
    end
    wait_done("wrap", 3);
    check("wrap nwrites", 32'(wr_addr.size() - base_wr), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wrap addr[%0d]", i), 32'(wr_addr[base_wr + i]), 32'(exp_wrap_addr[i]));
      check($sformatf("wrap data[%0d]", i), 32'(wr_data[base_wr + i]), 32'(exp_wrap_data[i]));
    end

    // Start held high for 5 cycles, then a second rise while still busy.
    base_wr = wr_addr.size();
    start_address = 8'h50;
    transfer_size = 8'd1;
    start = 1'b1;
    tick(1);
    check("held rd_en", 32'(uart_read_enable), 32'd1);
    tick(4);
    check("held still waiting", 32'(dut.current_state), 32'd1);
    start = 1'b0;
    start_address = 8'h70;
    transfer_size = 8'd5;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy rise ignored", 32'(dut.current_state), 32'd1);
    feed_byte("held", 8'h5A, 0);
    wait_done("held", 3);
    base_re = re_cnt;
    tick(3);
    check("held idle", 32'(dut.current_state), 32'd0);
    check("held no rerun", 32'(re_cnt - base_re), 32'd0);
    check("held nwrites", 32'(wr_addr.size() - base_wr), 32'd1);
    check("held addr", 32'(wr_addr[base_wr]), 32'h50);
    check("held data", 32'(wr_data[base_wr]), 32'h5A);

    // Reset in the middle of a 3-byte transfer.
    pulse_start(8'h10, 8'd3);
    feed_byte("midrst", 8'h01, 0);
    tick(2);
    #2;
    rstn = 1'b1;
    #1;
    check("midrst async state", 32'(dut.current_state), 32'd0);
    check("midrst async rd_en", 32'(uart_read_enable), 32'd0);
    check("midrst async wr_en", 32'(memory_write_enable), 32'd0);
    check("midrst async done", 32'(done), 32'd0);
    tick(3);
    rstn = 1'b0;
    tick(1);
    check("midrst after state", 32'(dut.current_state), 32'd0);
    check("midrst after done", 32'(done), 32'd0);

    // Zero size: immediate done, no request, no write.
    base_wr = wr_addr.size();
    base_re = re_cnt;
    pulse_start(8'h00, 8'd0);
    wait_done("zero", 2);
    tick(2);
    check("zero rd_en count", 32'(re_cnt - base_re), 32'd0);
    check("zero nwrites", 32'(wr_addr.size() - base_wr), 32'd0);
    check("zero state", 32'(dut.current_state), 32'd0);

    // Normal transfer after the reset.
    base_wr = wr_addr.size();
    pulse_start(8'h40, 8'd2);
    check("post done cleared", 32'(done), 32'd0);
    feed_byte("post[0]", 8'hC1, 1);
    feed_byte("post[1]", 8'hC2, 0);
    wait_done("post", 3);
    check("post nwrites", 32'(wr_addr.size() - base_wr), 32'd2);
    check("post addr0", 32'(wr_addr[base_wr]), 32'h40);
    check("post data0", 32'(wr_data[base_wr]), 32'hC1);
    check("post addr1", 32'(wr_addr[base_wr + 1]), 32'h41);
    check("post data1", 32'(wr_data[base_wr + 1]), 32'hC2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
